// File: rtl/gpr_pkg.sv
// gpr_pkg: shared defaults, FSM state type and the x0 address constant for the
// general-purpose register file (gpr_file) and its clear sequencer.
package gpr_pkg;

  localparam int GPR_XLEN  = 32;
  localparam int GPR_NREGS = 32;
  localparam int GPR_NRD   = 2;

  // x0 address, hardwired to read as zero
  localparam int GPR_ZERO  = 0;

  typedef enum logic {
    GPR_IDLE,
    GPR_CLEAR
  } gpr_state_t;

endpackage

// File: rtl/gpr_clr_seq.sv
// gpr_clr_seq: clear sequencer for the register file. After reset, or on
// clr_req while idle, it sweeps CLR_VAL into registers 1..NREGS-1, one per
// cycle, through an internal write port. busy is high for the whole sweep.
module gpr_clr_seq
  import gpr_pkg::*;
#(
  parameter int              XLEN    = GPR_XLEN,
  parameter int              NREGS   = GPR_NREGS,
  parameter logic [XLEN-1:0] CLR_VAL = '0,
  parameter int              AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_req,
  output logic            busy,
  output logic            clr_we,
  output logic [AW-1:0]   clr_addr,
  output logic [XLEN-1:0] clr_data
);

  localparam logic [AW-1:0] IDX_FIRST = AW'(1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(NREGS - 1);

  gpr_state_t    state_q;
  logic [AW-1:0] idx_q;
  logic          busy_q;

  // Sweep FSM: reset lands in CLEAR so storage is scrubbed without a reset net
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GPR_CLEAR;
      idx_q   <= IDX_FIRST;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        GPR_IDLE: begin
          if (clr_req) begin
            state_q <= GPR_CLEAR;
            idx_q   <= IDX_FIRST;
            busy_q  <= 1'b1;
          end
        end
        GPR_CLEAR: begin
          if (idx_q == IDX_LAST) begin
            state_q <= GPR_IDLE;
            idx_q   <= IDX_FIRST;
            busy_q  <= 1'b0;
          end else begin
            idx_q   <= idx_q + AW'(1);
          end
        end
        default: begin
          state_q <= GPR_CLEAR;
          idx_q   <= IDX_FIRST;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_we   = (state_q == GPR_CLEAR);
  assign clr_addr = idx_q;
  assign clr_data = CLR_VAL;

endmodule

// File: rtl/gpr_file.sv
// gpr_file: parametrised RISC-V general-purpose register file. One write port,
// NRD registered read ports, x0 hardwired to zero. Storage has no reset; the
// gpr_clr_seq sweep initialises it after reset or on clr_req.
// Build option: define GPR_BYPASS_EN for write-first forwarding of a same-cycle
// write to a read of the same (non-zero) address; default is read-first.
module gpr_file
  import gpr_pkg::*;
#(
  parameter int              XLEN    = GPR_XLEN,
  parameter int              NREGS   = GPR_NREGS,
  parameter int              NRD     = GPR_NRD,
  parameter logic [XLEN-1:0] CLR_VAL = '0,
  parameter int              AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  output logic                busy,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_valid,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(GPR_ZERO);

  reg [XLEN-1:0] mem [0:NREGS-1];

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic [XLEN-1:0] clr_data;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  gpr_clr_seq #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .CLR_VAL (CLR_VAL),
    .AW      (AW)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_data (clr_data)
  );

  // Write port mux: the sweep owns storage while busy, external writes otherwise
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_addr;
    mem_wdata = clr_data;
    if (busy) begin
      mem_we    = clr_we;
    end else begin
      mem_we    = wr_en && (wr_addr != ZERO_ADDR);
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
    end
  end

  // Storage update, deliberately without reset so it can map to LUT RAM
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   addr_p0;
    logic            fwd_p0;
    logic            acc_p0;
    logic [XLEN-1:0] rdata_p0;
    logic [XLEN-1:0] data_p1;
    logic            vld_p1;

    assign addr_p0 = rs_addr[p*AW +: AW];
    assign acc_p0  = rd_en[p] && !busy;

`ifdef GPR_BYPASS_EN
    assign fwd_p0 = wr_en && (wr_addr == addr_p0);
`else
    assign fwd_p0 = 1'b0;
`endif

    // x0 check takes priority, so forwarding never applies to address 0
    assign rdata_p0 = (addr_p0 == ZERO_ADDR) ? '0 :
                      fwd_p0                 ? wr_data :
                                               mem[addr_p0];

    // ---- stage p0 -> p1: registered read data, held when not accepted ----
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_p1 <= '0;
        vld_p1  <= 1'b0;
      end else begin
        vld_p1 <= acc_p0;
        if (acc_p0) begin
          data_p1 <= rdata_p0;
        end
      end
    end

    assign rs_data[p*XLEN +: XLEN] = data_p1;
    assign rs_valid[p]             = vld_p1;
  end

endmodule

// File: tb/tb_gpr_file.sv
// tb_gpr_file: randomized and directed bench for gpr_file with a behavioural
// reference model (array of registers plus a sweep countdown).
module tb_gpr_file;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;
`ifdef GPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                clr_req = 1'b0;
  logic                busy;
  logic [NRD-1:0]      rd_en = '0;
  logic [NRD*AW-1:0]   rs_addr = '0;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_valid;
  logic                wr_en = 1'b0;
  logic [AW-1:0]       wr_addr = '0;
  logic [XLEN-1:0]     wr_data = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  gpr_file #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .NRD     (NRD),
    .CLR_VAL ('0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .rd_en    (rd_en),
    .rs_addr  (rs_addr),
    .rs_data  (rs_data),
    .rs_valid (rs_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [XLEN-1:0] m_mem [NREGS];
  logic [XLEN-1:0] m_data [NRD];
  logic            m_valid [NRD];
  int              sweep_left = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        sweep_left = NREGS - 1;
        for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
        for (int p = 0; p < NRD; p++) begin
          m_data[p]  = '0;
          m_valid[p] = 1'b0;
        end
      end else if (sweep_left > 0) begin
        sweep_left--;
        for (int p = 0; p < NRD; p++) m_valid[p] = 1'b0;
      end else begin
        for (int p = 0; p < NRD; p++) begin
          logic [AW-1:0] a;
          a = rs_addr[p*AW +: AW];
          if (rd_en[p]) begin
            if (a == 0)                              m_data[p] = '0;
            else if (BYP && wr_en && wr_addr == a)   m_data[p] = wr_data;
            else                                     m_data[p] = m_mem[a];
            m_valid[p] = 1'b1;
          end else begin
            m_valid[p] = 1'b0;
          end
        end
        if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
        if (clr_req) begin
          sweep_left = NREGS - 1;
          for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  initial begin
    wait (chk_en);
    forever begin
      @(negedge clk);
      cyc++;
      total++;
      if (busy !== (sweep_left > 0)) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, sweep_left > 0);
      end
      for (int p = 0; p < NRD; p++) begin
        total++;
        if (rs_valid[p] !== m_valid[p]) begin
          bad++;
          $display("FAIL rs_valid[%0d] cyc=%0d got=%b want=%b", p, cyc, rs_valid[p], m_valid[p]);
        end
        total++;
        if (rs_data[p*XLEN +: XLEN] !== m_data[p]) begin
          bad++;
          $display("FAIL rs_data[%0d] cyc=%0d got=%h want=%h", p, cyc, rs_data[p*XLEN +: XLEN], m_data[p]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic quiet();
    rd_en   = '0;
    wr_en   = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_en[p] = 1'b1;
    rs_addr[p*AW +: AW] = a;
  endtask

  // Counts the negedges on which busy is seen high, starting at the current one
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  function automatic logic [XLEN-1:0] port_data(input int p);
    return rs_data[p*XLEN +: XLEN];
  endfunction

  initial begin
    int n;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd1);
    chk("reset valid", {30'd0, rs_valid}, 32'd0);
    chk("reset data0", port_data(0), 32'd0);
    chk("reset data1", port_data(1), 32'd0);

    // Reset sweep length
    rst = 1'b0;
    count_busy(n);
    chk("reset sweep len", 32'(n), 32'd31);

    // Write then read x5
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    quiet(); set_rd(0, 5'd5);
    @(negedge clk);
    quiet();
    chk("x5 data", port_data(0), 32'hDEAD_BEEF);
    chk("x5 valid", {31'd0, rs_valid[0]}, 32'd1);
    @(negedge clk);
    chk("x5 valid pulse", {31'd0, rs_valid[0]}, 32'd0);
    chk("x5 data hold", port_data(0), 32'hDEAD_BEEF);

    // x0 protection
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
    @(negedge clk);
    quiet(); set_rd(0, 5'd0); set_rd(1, 5'd0);
    @(negedge clk);
    quiet();
    chk("x0 port0", port_data(0), 32'd0);
    chk("x0 port1", port_data(1), 32'd0);
    chk("x0 valid", {30'd0, rs_valid}, 32'd3);

    // Same-cycle write/read of x7
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1111_1111;
    @(negedge clk);
    quiet();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
    set_rd(1, 5'd7);
    @(negedge clk);
    quiet();
    chk("bypass port1", port_data(1), BYP ? 32'hA5A5_A5A5 : 32'h1111_1111);
    set_rd(0, 5'd7);
    @(negedge clk);
    quiet();
    chk("x7 after write", port_data(0), 32'hA5A5_A5A5);

    // Random traffic with rare soft clears
    for (int i = 0; i < 600; i++) begin
      rd_en   = NRD'($urandom);
      rs_addr = (NRD*AW)'($urandom);
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_addr = AW'($urandom);
      wr_data = $urandom;
      if ($urandom_range(0, 3) == 0) rs_addr[AW-1:0] = wr_addr;
      clr_req = ($urandom_range(0, 150) == 0);
      @(negedge clk);
    end
    quiet();
    repeat (NREGS + 2) @(negedge clk);

    // Soft clear: fill, sweep with ignored traffic, verify zero
    for (int r = 1; r < NREGS; r++) begin
      wr_en = 1'b1; wr_addr = AW'(r); wr_data = $urandom | 32'h1;
      @(negedge clk);
    end
    quiet();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      chk("valid low while busy", {30'd0, rs_valid}, 32'd0);
      rd_en = NRD'($urandom); rs_addr = (NRD*AW)'($urandom);
      wr_en = 1'b1; wr_addr = AW'($urandom); wr_data = $urandom | 32'h1;
      n++;
      @(negedge clk);
    end
    quiet();
    chk("soft sweep len", 32'(n), 32'd31);
    for (int r = 1; r < NREGS; r++) begin
      set_rd(0, AW'(r)); set_rd(1, AW'(NREGS - r));
      @(negedge clk);
      quiet();
      chk("cleared port0", port_data(0), 32'd0);
      chk("cleared port1", port_data(1), 32'd0);
    end

    // Reset in the middle of a soft sweep
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    chk("midsweep restart len", 32'(n), 32'd31);
    set_rd(0, 5'd5);
    @(negedge clk);
    quiet();
    chk("after restart x5", port_data(0), 32'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
